pipeline_control_unit: RTL and testbench

- Central hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Sits beside the forwarding unit and drives stall and flush enables into the PC, IF/ID, ID/EX and EX stages.
- Resolves three conditions:
  - load-use hazards, by inserting a bubble;
  - taken branches/jumps, by flushing the front end for a configurable number of cycles;
  - multi-cycle MUL/DIV operations, by starting the MDU and freezing the pipeline until done or timeout.

---
 rtl/riscv_ctrl_pkg.sv | 14 +
 rtl/pipeline_control_unit_if.sv | 37 +++
 rtl/pipeline_control_unit_load_use_detector.sv | 24 ++
 rtl/pipeline_control_unit.sv | 153 +++++++++++++++
 tb/tb_pipeline_control_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM state encoding, default register-address width and the x0 address.
package riscv_ctrl_pkg;

    localparam int          DEFAULT_REG_ADDR_W = 5;
    localparam int unsigned X0_ADDR            = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MDU_BUSY = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Decode/EX hazard inputs, MDU handshake and the stall/flush enables the
// controller drives into the pipeline. The controller uses the slave modport.
interface pipeline_control_unit_if #(
    parameter int REG_ADDR_W = riscv_ctrl_pkg::DEFAULT_REG_ADDR_W
);
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  ex_mdu_op;
    logic                  mdu_done;

    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_stall;
    logic                  mdu_start;
    logic                  mdu_err;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rd_addr, ex_mem_read, ex_branch_taken, ex_mdu_op, mdu_done,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_flush,
               ex_stall, mdu_start, mdu_err
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rd_addr, ex_mem_read, ex_branch_taken, ex_mdu_op, mdu_done,
        output pc_stall, if_id_stall, if_id_flush, id_ex_flush,
               ex_stall, mdu_start, mdu_err
    );
endinterface

// File: rtl/pipeline_control_unit_load_use_detector.sv
// Combinational load-use hazard check: a load in EX writes a register the
// decode instruction actually reads. x0 never creates a hazard.
module load_use_detector
    import riscv_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mem_read,
    output logic                  hazard
);
    logic rs1_match;
    logic rs2_match;
    logic rd_is_x0;

    assign rs1_match = id_rs1_used && (id_rs1_addr == ex_rd_addr);
    assign rs2_match = id_rs2_used && (id_rs2_addr == ex_rd_addr);
    assign rd_is_x0  = (ex_rd_addr == REG_ADDR_W'(X0_ADDR));
    assign hazard    = ex_mem_read && !rd_is_x0 && (rs1_match || rs2_match);
endmodule

// File: rtl/pipeline_control_unit.sv
// Hazard and sequencing controller: load-use bubbles, branch front-end flush,
// MUL/DIV freeze with timeout. Optional perf counters: PIPELINE_PERF_CNT_EN.
module pipeline_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = DEFAULT_REG_ADDR_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int MDU_TIMEOUT  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipeline_control_unit_if.slave  ctrl
`ifdef PIPELINE_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             flush_events
`endif
);
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int MDU_W   = $clog2(MDU_TIMEOUT);

    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(1);
    localparam logic [MDU_W-1:0]   MDU_LAST   = MDU_W'(MDU_TIMEOUT - 1);

    ctrl_state_e        state_q, state_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [MDU_W-1:0]   mdu_cnt_q, mdu_cnt_d;

    logic hazard;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic ex_stall, mdu_start, mdu_err;

    load_use_detector #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
        .id_rs1_addr (ctrl.id_rs1_addr),
        .id_rs2_addr (ctrl.id_rs2_addr),
        .id_rs1_used (ctrl.id_rs1_used),
        .id_rs2_used (ctrl.id_rs2_used),
        .ex_rd_addr  (ctrl.ex_rd_addr),
        .ex_mem_read (ctrl.ex_mem_read),
        .hazard      (hazard)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            mdu_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            mdu_cnt_q   <= mdu_cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        mdu_cnt_d   = mdu_cnt_q;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_stall    = 1'b0;
        mdu_start   = 1'b0;
        mdu_err     = 1'b0;

        // Outputs stay quiet while reset is held, whatever the inputs do.
        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (ctrl.ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = FLUSH;
                            flush_cnt_d = FLUSH_INIT;
                        end
                    end else if (ctrl.ex_mdu_op) begin
                        mdu_start   = 1'b1;
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        ex_stall    = 1'b1;
                        state_d     = MDU_BUSY;
                        mdu_cnt_d   = '0;
                    end else if (hazard) begin
                        // The load leaves EX next cycle, so one bubble is enough.
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end

                FLUSH: begin
                    if_id_flush = 1'b1;
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d = RUN;
                    end
                end

                MDU_BUSY: begin
                    if (ctrl.mdu_done) begin
                        state_d   = RUN;
                        mdu_cnt_d = '0;
                    end else if (mdu_cnt_q == MDU_LAST) begin
                        mdu_err   = 1'b1;
                        state_d   = RUN;
                        mdu_cnt_d = '0;
                    end else begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        ex_stall    = 1'b1;
                        mdu_cnt_d   = mdu_cnt_q + MDU_W'(1);
                    end
                end

                default: state_d = RUN;
            endcase
        end
    end

    assign ctrl.pc_stall    = pc_stall;
    assign ctrl.if_id_stall = if_id_stall;
    assign ctrl.if_id_flush = if_id_flush;
    assign ctrl.id_ex_flush = id_ex_flush;
    assign ctrl.ex_stall    = ex_stall;
    assign ctrl.mdu_start   = mdu_start;
    assign ctrl.mdu_err     = mdu_err;

`ifdef PIPELINE_PERF_CNT_EN
    logic flush_entry;
    assign flush_entry = (state_q == RUN) && ctrl.ex_branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush_entry && (flush_events != '1)) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench: instance A (FLUSH_CYCLES=3, MDU_TIMEOUT=64) covers load-use,
// branch flush and MDU done; instance B (MDU_TIMEOUT=8) covers timeout and reset.
module tb_pipeline_control_unit;
    import riscv_ctrl_pkg::*;

    localparam int AW = DEFAULT_REG_ADDR_W;

    // Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    //                       ex_stall, mdu_start, mdu_err}
    localparam int O_NONE  = 'b0000000;
    localparam int O_LU    = 'b1101000;
    localparam int O_BR    = 'b0011000;
    localparam int O_FL    = 'b0010000;
    localparam int O_START = 'b1100110;
    localparam int O_BUSY  = 'b1100100;
    localparam int O_ERR   = 'b0000001;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_control_unit_if #(.REG_ADDR_W(AW)) a_if ();
    pipeline_control_unit_if #(.REG_ADDR_W(AW)) b_if ();

`ifdef PIPELINE_PERF_CNT_EN
    logic [31:0] a_stall_cycles, a_flush_events, b_stall_cycles, b_flush_events;
`endif

    pipeline_control_unit #(.REG_ADDR_W(AW), .FLUSH_CYCLES(3), .MDU_TIMEOUT(64)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (a_if)
`ifdef PIPELINE_PERF_CNT_EN
        ,
        .stall_cycles (a_stall_cycles),
        .flush_events (a_flush_events)
`endif
    );

    pipeline_control_unit #(.REG_ADDR_W(AW), .FLUSH_CYCLES(2), .MDU_TIMEOUT(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (b_if)
`ifdef PIPELINE_PERF_CNT_EN
        ,
        .stall_cycles (b_stall_cycles),
        .flush_events (b_flush_events)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'b%0b expected 'b%0b", tag, got, exp);
        end
    endtask

    function automatic int outs_a();
        return int'({a_if.pc_stall, a_if.if_id_stall, a_if.if_id_flush, a_if.id_ex_flush,
                     a_if.ex_stall, a_if.mdu_start, a_if.mdu_err});
    endfunction

    function automatic int outs_b();
        return int'({b_if.pc_stall, b_if.if_id_stall, b_if.if_id_flush, b_if.id_ex_flush,
                     b_if.ex_stall, b_if.mdu_start, b_if.mdu_err});
    endfunction

    task automatic idle_a();
        a_if.id_rs1_addr = '0; a_if.id_rs2_addr = '0;
        a_if.id_rs1_used = 1'b0; a_if.id_rs2_used = 1'b0;
        a_if.ex_rd_addr = '0; a_if.ex_mem_read = 1'b0;
        a_if.ex_branch_taken = 1'b0; a_if.ex_mdu_op = 1'b0; a_if.mdu_done = 1'b0;
    endtask

    task automatic idle_b();
        b_if.id_rs1_addr = '0; b_if.id_rs2_addr = '0;
        b_if.id_rs1_used = 1'b0; b_if.id_rs2_used = 1'b0;
        b_if.ex_rd_addr = '0; b_if.ex_mem_read = 1'b0;
        b_if.ex_branch_taken = 1'b0; b_if.ex_mdu_op = 1'b0; b_if.mdu_done = 1'b0;
    endtask

    task automatic lu_a(input logic mr, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic u1, input logic u2);
        a_if.ex_mem_read = mr; a_if.ex_rd_addr = rd;
        a_if.id_rs1_addr = rs1; a_if.id_rs2_addr = rs2;
        a_if.id_rs1_used = u1; a_if.id_rs2_used = u2;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked 3 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        int stall_n, start_n, busy_ok, err_n;

        rst_n = 1'b0;
        idle_a();
        idle_b();
        #3;
        check("reset_a", outs_a(), O_NONE);
        check("reset_b", outs_b(), O_NONE);
        a_if.ex_branch_taken = 1'b1;
        b_if.ex_mdu_op = 1'b1;
        #1;
        check("reset_gate_a", outs_a(), O_NONE);
        check("reset_gate_b", outs_b(), O_NONE);
        idle_a();
        idle_b();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); settle();
        check("post_reset_a", outs_a(), O_NONE);

        // Load-use bubble lasts exactly one cycle.
        cyc(); lu_a(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1); settle();
        check("lu_rs2", outs_a(), O_LU);
        cyc(); idle_a(); settle();
        check("lu_cleared", outs_a(), O_NONE);
        cyc(); lu_a(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); settle();
        check("lu_x0", outs_a(), O_NONE);
        cyc(); lu_a(1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b1); settle();
        check("lu_rs1", outs_a(), O_LU);
        cyc(); lu_a(1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0); settle();
        check("lu_unused", outs_a(), O_NONE);
        cyc(); lu_a(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1); settle();
        check("lu_not_load", outs_a(), O_NONE);

        // Branch: three flush cycles, ID/EX bubble only in the first.
        cyc(); idle_a(); a_if.ex_branch_taken = 1'b1; settle();
        check("br_c0", outs_a(), O_BR);
        cyc(); a_if.ex_mdu_op = 1'b1; settle();
        check("br_c1_ignore_ex", outs_a(), O_FL);
        cyc(); idle_a(); a_if.mdu_done = 1'b1; settle();
        check("br_c2_ignore_done", outs_a(), O_FL);
        cyc(); settle();
        check("br_done_run", outs_a(), O_NONE);

        // Branch together with a load-use match: flush only, no PC stall.
        cyc(); idle_a(); lu_a(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
        a_if.ex_branch_taken = 1'b1; settle();
        check("sim_c0", outs_a(), O_BR);
        cyc(); a_if.ex_branch_taken = 1'b0; settle();
        check("sim_c1", outs_a(), O_FL);
        cyc(); settle();
        check("sim_c2", outs_a(), O_FL);
        cyc(); idle_a(); settle();
        check("sim_run", outs_a(), O_NONE);

        // MDU: done arrives after 10 busy cycles; stalls high for 11 cycles.
        stall_n = 0; start_n = 0; busy_ok = 0;
        cyc(); a_if.ex_mdu_op = 1'b1; settle();
        check("mdu_start", outs_a(), O_START);
        stall_n += int'(a_if.pc_stall); start_n += int'(a_if.mdu_start);
        for (int i = 1; i <= 10; i++) begin
            cyc(); a_if.ex_mdu_op = 1'b0; settle();
            if (outs_a() == O_BUSY) busy_ok++;
            stall_n += int'(a_if.pc_stall); start_n += int'(a_if.mdu_start);
        end
        cyc(); a_if.mdu_done = 1'b1; settle();
        check("mdu_done_drop", outs_a(), O_NONE);
        stall_n += int'(a_if.pc_stall); start_n += int'(a_if.mdu_start);
        check("mdu_busy_pattern", busy_ok, 10);
        check("mdu_stall_cycles", stall_n, 11);
        check("mdu_start_pulses", start_n, 1);
        cyc(); a_if.mdu_done = 1'b0; settle();
        check("mdu_back_run", outs_a(), O_NONE);

        // Timeout on B: MDU_ERR in cycle 8 after start, then RUN.
        busy_ok = 0;
        cyc(); b_if.ex_mdu_op = 1'b1; settle();
        check("to_start", outs_b(), O_START);
        for (int i = 1; i <= 7; i++) begin
            cyc(); b_if.ex_mdu_op = 1'b0; settle();
            if (outs_b() == O_BUSY) busy_ok++;
        end
        check("to_busy_pattern", busy_ok, 7);
        cyc(); settle();
        check("to_err", outs_b(), O_ERR);
        cyc(); settle();
        check("to_err_once", outs_b(), O_NONE);
        cyc(); b_if.ex_branch_taken = 1'b1; settle();
        check("to_run_br", outs_b(), O_BR);
        cyc(); b_if.ex_branch_taken = 1'b0; settle();
        check("to_run_fl", outs_b(), O_FL);
        cyc(); settle();
        check("to_run_idle", outs_b(), O_NONE);

        // Done coinciding with timeout: done wins, no error.
        cyc(); b_if.ex_mdu_op = 1'b1; settle();
        check("dt_start", outs_b(), O_START);
        for (int i = 1; i <= 7; i++) begin
            cyc(); b_if.ex_mdu_op = 1'b0; settle();
        end
        check("dt_last_busy", outs_b(), O_BUSY);
        cyc(); b_if.mdu_done = 1'b1; settle();
        check("dt_done_wins", outs_b(), O_NONE);
        cyc(); b_if.mdu_done = 1'b0; settle();
        check("dt_run", outs_b(), O_NONE);

        // Reset in the middle of MDU_BUSY on B.
        cyc(); b_if.ex_mdu_op = 1'b1; settle();
        check("rst_start", outs_b(), O_START);
        for (int i = 1; i <= 3; i++) begin
            cyc(); b_if.ex_mdu_op = 1'b0; settle();
        end
        cyc(); settle();
        check("rst_pre_busy", outs_b(), O_BUSY);
        rst_n = 1'b0;
        #1;
        check("rst_mid_drop", outs_b(), O_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        err_n = 0; stall_n = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(); settle();
            err_n   += int'(b_if.mdu_err);
            stall_n += int'(b_if.pc_stall);
        end
        check("rst_no_err", err_n, 0);
        check("rst_no_stall", stall_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
